// File: rtl/conv_encoder_frame.sv
// conv_encoder_frame: framed rate-1/2 feedforward convolutional encoder, K=3..6, zero-tail terminated.
// Defining CONV_ENC_STATS_EN adds a 16-bit frame_count output of completed frames.
module conv_encoder_frame #(
    parameter int FRAME_LEN = 13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] choose_constraint_length,
    input  logic       frame_start,
    input  logic       in_bit,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [1:0] encoded_bits,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy,
    output logic       cfg_err
`ifdef CONV_ENC_STATS_EN
    ,
    output logic [15:0] frame_count
`endif
);
    typedef enum logic [1:0] {IDLE, DATA, TAIL, DRAIN} state_t;
    state_t     r_state, w_next;
    logic [2:0] r_k, r_tcnt, w_k_sel;
    logic [4:0] r_hist;
    logic [7:0] r_cnt;
    logic [1:0] r_sym, w_sym;
    logic       r_valid, r_last;
    logic       w_k_legal, w_start, w_load_ok, w_in_acc, w_tail_ld, w_tail_end, w_data_end, w_last_hs, w_u;
    logic [5:0] w_win, w_g0, w_g1;

    assign w_k_legal  = (choose_constraint_length >= 3'd3) && (choose_constraint_length <= 3'd6);
    assign w_k_sel    = w_k_legal ? choose_constraint_length : 3'd3;
    assign w_start    = (r_state == IDLE) && frame_start;
    assign w_load_ok  = !r_valid || out_ready;
    assign w_in_acc   = (r_state == DATA) && in_valid && w_load_ok;
    assign w_data_end = w_in_acc && (r_cnt == 8'(FRAME_LEN - 1));
    assign w_tail_ld  = (r_state == TAIL) && w_load_ok;
    assign w_tail_end = w_tail_ld && (r_tcnt == r_k - 3'd2);
    assign w_last_hs  = r_valid && out_ready && r_last;

    // Generators left-aligned in 6 bits so the MSB tap always meets the current input
    assign w_g0  = (r_k == 3'd3) ? 6'b111000 : (r_k == 3'd4) ? 6'b110100 :
                   (r_k == 3'd5) ? 6'b100110 : 6'b101011;
    assign w_g1  = (r_k == 3'd3) ? 6'b101000 : (r_k == 3'd4) ? 6'b111100 :
                   (r_k == 3'd5) ? 6'b111010 : 6'b111101;
    assign w_u   = w_in_acc ? in_bit : 1'b0;
    assign w_win = {w_u, r_hist[0], r_hist[1], r_hist[2], r_hist[3], r_hist[4]};
    assign w_sym = {^(w_win & w_g0), ^(w_win & w_g1)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        in_ready = (r_state == DATA) && w_load_ok;
        busy     = (r_state != IDLE);
        cfg_err  = w_start && !w_k_legal && !rst;
        case (r_state)
            IDLE:    w_next = frame_start ? DATA : IDLE;
            DATA:    w_next = w_data_end ? TAIL : DATA;
            TAIL:    w_next = w_tail_end ? DRAIN : TAIL;
            default: w_next = w_last_hs ? IDLE : DRAIN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k     <= 3'd3;
            r_hist  <= '0;
            r_cnt   <= '0;
            r_tcnt  <= '0;
            r_sym   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            if (w_start) begin
                r_k    <= w_k_sel;
                r_hist <= '0;
                r_cnt  <= '0;
                r_tcnt <= '0;
            end
            if (w_in_acc) begin
                r_hist <= {r_hist[3:0], in_bit};
                r_cnt  <= r_cnt + 8'd1;
            end
            if (w_tail_ld) begin
                r_hist <= {r_hist[3:0], 1'b0};
                r_tcnt <= r_tcnt + 3'd1;
            end
            if (w_in_acc || w_tail_ld) begin
                r_sym   <= w_sym;
                r_valid <= 1'b1;
                r_last  <= w_tail_end;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign encoded_bits = r_sym;
    assign out_valid    = r_valid;
    assign out_last     = r_last;

`ifdef CONV_ENC_STATS_EN
    logic [15:0] r_frame_count;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_frame_count <= '0;
        else if (w_last_hs) r_frame_count <= r_frame_count + 16'd1;
    end
    assign frame_count = r_frame_count;
`endif
endmodule

// File: tb/tb_conv_encoder_frame.sv
// tb_conv_encoder_frame: randomized frame-level bench for conv_encoder_frame against a convolution-sum model.
module tb_conv_encoder_frame;
    localparam int FL = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] choose_constraint_length = 3'd3;
    logic       frame_start = 1'b0;
    logic       in_bit = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] encoded_bits;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_last;
    logic       busy;
    logic       cfg_err;
`ifdef CONV_ENC_STATS_EN
    logic [15:0] frame_count;
`endif

    int total = 0;
    int passed = 0;
    int nframes = 0;
    logic [2:0] exp_q[$];
    logic [2:0] got[$];

    conv_encoder_frame #(.FRAME_LEN(FL)) dut (
        .clk(clk),
        .rst(rst),
        .choose_constraint_length(choose_constraint_length),
        .frame_start(frame_start),
        .in_bit(in_bit),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .encoded_bits(encoded_bits),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last),
        .busy(busy),
        .cfg_err(cfg_err)
`ifdef CONV_ENC_STATS_EN
        ,
        .frame_count(frame_count)
`endif
    );

    always #5 clk = ~clk;

    // Expected symbols as {last, G0 parity, G1 parity}, from the direct convolution sum
    function automatic void build_model(input int k, input logic [FL-1:0] bits);
        int g0, g1, u, p0, p1;
        exp_q.delete();
        case (k)
            4:       begin g0 = 'o15; g1 = 'o17; end
            5:       begin g0 = 'o23; g1 = 'o35; end
            6:       begin g0 = 'o53; g1 = 'o75; end
            default: begin g0 = 'o7;  g1 = 'o5;  end
        endcase
        for (int t = 0; t < FL + k - 1; t++) begin
            p0 = 0;
            p1 = 0;
            for (int j = 0; j < k; j++) begin
                u = (t - j >= 0 && t - j < FL) ? int'(bits[t - j]) : 0;
                p0 ^= u & ((g0 >> (k - 1 - j)) & 1);
                p1 ^= u & ((g1 >> (k - 1 - j)) & 1);
            end
            exp_q.push_back({t == FL + k - 2, p0[0], p1[0]});
        end
    endfunction

    // mode 0: out_ready high and in_valid continuous; 1: random; 2: 3-cycle stall on 2nd symbol
    task automatic run_frame(input string name, input logic [2:0] ksel, input logic [FL-1:0] bits,
                             input int mode, input bit poke);
        int idx = 0, cyc = 0, first = -1, lastc = -1, stall = 0;
        bit done = 0, acc, hold = 0;
        logic [2:0] held = '0;
        got.delete();
        @(posedge clk); #1;
        choose_constraint_length = ksel;
        frame_start = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (cfg_err !== (ksel < 3'd3 || ksel > 3'd6)) $display("FAIL %s cfg_err got %b want %b", name, cfg_err, (ksel < 3'd3 || ksel > 3'd6)); else passed++;
        @(posedge clk); #1;
        frame_start = 1'b0;
        choose_constraint_length = 3'($urandom);
        while (!done && cyc < 500) begin
            in_valid = (idx < FL) && (mode != 1 || $urandom_range(0, 3) != 0);
            in_bit = (idx < FL) ? bits[idx] : 1'b0;
            out_ready = (mode == 1) ? ($urandom_range(0, 2) != 0) : !(mode == 2 && got.size() == 1 && stall < 3);
            if (!out_ready) stall++;
            frame_start = poke && cyc == 2;
            if (poke) choose_constraint_length = 3'd7;
            @(negedge clk);
            total++; if (cfg_err !== 1'b0) $display("FAIL %s cfg_err_midframe got %b want 0", name, cfg_err); else passed++;
            total++; if (out_valid && !out_ready && in_ready) $display("FAIL %s in_ready_stall got 1 want 0", name); else passed++;
            if (hold) begin
                total++; if ({out_valid, out_last, encoded_bits} !== {1'b1, held}) $display("FAIL %s hold got %b want %b", name, {out_valid, out_last, encoded_bits}, {1'b1, held}); else passed++;
            end
            hold = out_valid && !out_ready;
            held = {out_last, encoded_bits};
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                got.push_back({out_last, encoded_bits});
                if (first < 0) first = cyc;
                lastc = cyc;
                done = out_last;
            end
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        frame_start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        if (done) nframes++;
        total++; if (!done) $display("FAIL %s timeout got no out_last want out_last within 500 cycles", name); else passed++;
        total++; if (got.size() != exp_q.size()) $display("FAIL %s symbol_count got %0d want %0d", name, got.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            total++; if (got[i] !== exp_q[i]) $display("FAIL %s sym%0d {last,bits} got %b want %b", name, i, got[i], exp_q[i]); else passed++;
        end
        if (mode == 0) begin
            total++; if (lastc - first != exp_q.size() - 1) $display("FAIL %s throughput span got %0d want %0d", name, lastc - first, exp_q.size() - 1); else passed++;
        end
        @(negedge clk);
        total++; if ({busy, out_valid} !== 2'b00) $display("FAIL %s idle_after {busy,out_valid} got %b want 00", name, {busy, out_valid}); else passed++;
    endtask

    task automatic load_basic_expect();
        exp_q.delete();
        exp_q.push_back(3'b011);
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b111);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        frame_start = 1'b1;
        choose_constraint_length = 3'd7;
        repeat (2) @(negedge clk);
        total++; if ({encoded_bits, out_valid, out_last, in_ready, busy, cfg_err} !== 7'b0) $display("FAIL reset outputs got %b want 0000000", {encoded_bits, out_valid, out_last, in_ready, busy, cfg_err}); else passed++;
`ifdef CONV_ENC_STATS_EN
        total++; if (frame_count !== 16'd0) $display("FAIL reset frame_count got %0d want 0", frame_count); else passed++;
`endif
        @(posedge clk); #1;
        frame_start = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        load_basic_expect();
        run_frame("basic_k3", 3'd3, 4'b1101, 0, 0);
    endtask

    task automatic test_stall();
        load_basic_expect();
        run_frame("stall_k3", 3'd3, 4'b1101, 2, 0);
    endtask

    task automatic test_k6_zeros();
        build_model(6, 4'b0000);
        run_frame("k6_zeros", 3'd6, 4'b0000, 0, 0);
    endtask

    task automatic test_illegal_k();
        logic [FL-1:0] b;
        b = FL'($urandom);
        build_model(3, b);
        run_frame("illegal_k7", 3'd7, b, 0, 0);
        b = FL'($urandom);
        build_model(3, b);
        run_frame("illegal_k0", 3'd0, b, 1, 0);
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1;
        choose_constraint_length = 3'd3;
        frame_start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        in_valid = 1'b1;
        in_bit = 1'b1;
        @(posedge clk); #1;
        in_bit = 1'b0;
        @(posedge clk); #1;
        total++; if ({out_valid, busy} !== 2'b11) $display("FAIL async_pre {out_valid,busy} got %b want 11", {out_valid, busy}); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if ({encoded_bits, out_valid, out_last, in_ready, busy, cfg_err} !== 7'b0) $display("FAIL async_reset outputs got %b want 0000000", {encoded_bits, out_valid, out_last, in_ready, busy, cfg_err}); else passed++;
        in_valid = 1'b0;
        nframes = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        load_basic_expect();
        run_frame("after_reset", 3'd3, 4'b1101, 0, 0);
    endtask

    task automatic test_random();
        int k;
        logic [FL-1:0] b;
        for (int f = 0; f < 8; f++) begin
            k = $urandom_range(3, 6);
            b = FL'($urandom);
            build_model(k, b);
            run_frame($sformatf("random%0d_k%0d", f, k), 3'(k), b, 1, 0);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        logic [FL-1:0] b;
        for (int f = 0; f < 3; f++) begin
            k = $urandom_range(3, 6);
            b = FL'($urandom);
            build_model(k, b);
            run_frame($sformatf("b2b%0d", f), 3'(k), b, 0, 1);
`ifdef CONV_ENC_STATS_EN
            total++; if (frame_count !== 16'(nframes)) $display("FAIL b2b%0d frame_count got %0d want %0d", f, frame_count, nframes); else passed++;
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_k6_zeros();
        test_illegal_k();
        test_async_reset();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
